// File: rtl/softmax_row_max_sub.sv
// softmax_row_max_sub: ping-pong row buffer that finds each row's max and
// re-emits the row tile by tile as saturated (x - row_max), all values <= 0.
// Ports: clk, rst_n (sync, active-low); in_valid/in_data input tiles;
// drain_hold test hook that holds off drain start (tie to 0 in use);
// out_valid/out_data/out_last/out_row_max/out_done output tiles;
// overflow sticky flag for tiles dropped because no bank was free.
module softmax_row_max_sub #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROW        = 256,
  parameter int COL        = 64,
  parameter int TILE_SIZE  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [TILE_SIZE*WIDTH-1:0] in_data,
  input  logic                       drain_hold,
  output logic                       out_valid,
  output logic [TILE_SIZE*WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic [WIDTH-1:0]           out_row_max,
  output logic                       out_done,
  output logic                       overflow
);
  localparam int TPR = COL / TILE_SIZE;
  localparam int TW  = TILE_SIZE * WIDTH;
  localparam int TA  = (TPR > 1) ? $clog2(TPR) : 1;
  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [TA-1:0] TLAST = TA'(TPR - 1);
  localparam logic [RW-1:0] RLAST = RW'(ROW - 1);

  if (COL % TILE_SIZE != 0 || FRAC_WIDTH >= WIDTH) begin : g_bad_cfg
    $error("softmax_row_max_sub: bad parameters");
  end

  typedef enum logic [1:0] {
    EMPTY, FILLING, FULL, DRAINING
  } bank_e;

  bank_e bst [2];
  bank_e bst_n [2];

  logic          wr_bank, rd_bank;
  logic [TA-1:0] wr_tile, rd_tile;
  logic [RW-1:0] row_cnt;
  logic [WIDTH-1:0] run_max, run_nxt;
  logic [WIDTH-1:0] bank_max [2];
  logic [TW-1:0]    mem [2][TPR];
  logic [TW-1:0]    ram_q;
  logic [WIDTH-1:0] s1_max;
  logic             s1_valid, s1_last;

  logic rd_act, rd_last, idle_start, chain_start;
  logic wr_ok, wr_fin;

  assign rd_act  = (bst[rd_bank] == DRAINING);
  assign rd_last = rd_act && (rd_tile == TLAST);
  assign idle_start  = !rd_act && (bst[rd_bank] == FULL) && !drain_hold;
  // Second bank starts on the cycle after the first ends: no bubble.
  assign chain_start = rd_last && (bst[~rd_bank] == FULL) && !drain_hold;

  // A bank finishing its last read this cycle may already take new data.
  assign wr_ok  = in_valid &&
                  (bst[wr_bank] == EMPTY || bst[wr_bank] == FILLING ||
                   (rd_last && rd_bank == wr_bank));
  assign wr_fin = wr_ok && (wr_tile == TLAST);

  logic signed [WIDTH-1:0] lane, tile_max;
  always_comb begin
    tile_max = $signed(in_data[WIDTH-1:0]);
    lane     = tile_max;
    for (int i = 1; i < TILE_SIZE; i++) begin
      lane = $signed(in_data[i*WIDTH +: WIDTH]);
      if (lane > tile_max) tile_max = lane;
    end
  end

  assign run_nxt = (wr_tile == '0 || tile_max > $signed(run_max))
                 ? tile_max : run_max;

  always_comb begin
    bst_n[0] = bst[0];
    bst_n[1] = bst[1];
    if (rd_last)     bst_n[rd_bank]  = EMPTY;
    if (idle_start)  bst_n[rd_bank]  = DRAINING;
    if (chain_start) bst_n[~rd_bank] = DRAINING;
    if (wr_ok)       bst_n[wr_bank]  = wr_fin ? FULL : FILLING;
  end

  // d is computed one bit wider; only the low side can overflow.
  logic [WIDTH:0] diff;
  logic [TW-1:0]  shifted;
  always_comb begin
    diff    = '0;
    shifted = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      diff = {ram_q[i*WIDTH+WIDTH-1], ram_q[i*WIDTH +: WIDTH]}
           - {s1_max[WIDTH-1], s1_max};
      shifted[i*WIDTH +: WIDTH] = (diff[WIDTH] & ~diff[WIDTH-1])
        ? {1'b1, {(WIDTH-1){1'b0}}} : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)  mem[wr_bank][wr_tile] <= in_data;
    if (wr_fin) bank_max[wr_bank] <= run_nxt;
    ram_q  <= mem[rd_bank][rd_tile];
    s1_max <= bank_max[rd_bank];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bst[0]      <= EMPTY;
      bst[1]      <= EMPTY;
      wr_bank     <= 1'b0;
      wr_tile     <= '0;
      rd_bank     <= 1'b0;
      rd_tile     <= '0;
      run_max     <= '0;
      row_cnt     <= '0;
      overflow    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_row_max <= '0;
      out_done    <= 1'b0;
    end else begin
      bst[0] <= bst_n[0];
      bst[1] <= bst_n[1];
      if (wr_ok) begin
        run_max <= run_nxt;
        if (wr_fin) begin
          wr_tile <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_tile <= wr_tile + TA'(1);
        end
      end
      if (in_valid && !wr_ok) overflow <= 1'b1;
      if (rd_act) begin
        if (rd_last) begin
          rd_tile <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_tile <= rd_tile + TA'(1);
        end
      end
      s1_valid  <= rd_act;
      s1_last   <= rd_last;
      out_valid <= s1_valid;
      out_last  <= s1_valid & s1_last;
      out_done  <= s1_valid & s1_last & (row_cnt == RLAST);
      if (s1_valid) begin
        out_data    <= shifted;
        out_row_max <= s1_max;
      end
      if (s1_valid & s1_last)
        row_cnt <= (row_cnt == RLAST) ? '0 : row_cnt + RW'(1);
    end
  end
endmodule

// File: tb/tb_softmax_row_max_sub.sv
// tb_softmax_row_max_sub: directed bench with a row-level golden model
// and a per-cycle output comparator for softmax_row_max_sub.
module tb_softmax_row_max_sub;
  localparam int W    = 16;
  localparam int TS   = 8;
  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int TPR  = COLS / TS;
  localparam int TW   = TS * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [TW-1:0] in_data = '0;
  logic          drain_hold = 1'b0;
  logic          out_valid, out_last, out_done, overflow;
  logic [TW-1:0] out_data;
  logic [W-1:0]  out_row_max;

  softmax_row_max_sub #(
    .WIDTH(W), .FRAC_WIDTH(8), .ROW(ROWS), .COL(COLS), .TILE_SIZE(TS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .drain_hold(drain_hold), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_row_max(out_row_max), .out_done(out_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] d;
    logic          last;
    logic [W-1:0]  m;
    logic          done;
  } exp_t;

  exp_t          expq[$];
  logic [TW-1:0] part[$];
  int            row_idx = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [TW-1:0] act,
                     input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ln(input logic [TW-1:0] t, input int i);
    return t[i*W +: W];
  endfunction

  function automatic logic [TW-1:0] mk(input int base, input int step);
    logic [TW-1:0] t;
    for (int i = 0; i < TS; i++) t[i*W +: W] = 16'(base + i * step);
    return t;
  endfunction

  // Row-level model: a row becomes visible once all its tiles arrived;
  // its max is the signed max of every lane; outputs are x - max, clamped.
  task automatic model_tile(input logic [TW-1:0] t);
    int mx;
    int v;
    logic [TW-1:0] tt;
    exp_t e;
    part.push_back(t);
    if (part.size() == TPR) begin
      mx = -100000;
      for (int k = 0; k < TPR; k++) begin
        tt = part[k];
        for (int i = 0; i < TS; i++) begin
          v = int'($signed(tt[i*W +: W]));
          if (v > mx) mx = v;
        end
      end
      for (int k = 0; k < TPR; k++) begin
        tt = part[k];
        for (int i = 0; i < TS; i++) begin
          v = int'($signed(tt[i*W +: W])) - mx;
          if (v < -32768) v = -32768;
          e.d[i*W +: W] = 16'(v);
        end
        e.last = (k == TPR - 1);
        e.m    = 16'(mx);
        e.done = e.last && (row_idx == ROWS - 1);
        expq.push_back(e);
      end
      row_idx = (row_idx + 1) % ROWS;
      part.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected: out_valid=1 with %h, expected no beat",
                 out_data);
      end else begin
        e = expq.pop_front();
        chk("cmp_data", out_data, e.d);
        chk("cmp_last", out_last, e.last);
        chk("cmp_rowmax", out_row_max, e.m);
        chk("cmp_done", out_done, e.done);
      end
    end
  end

  task automatic beat(input logic [TW-1:0] t, input bit drop);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = t;
    if (!drop) model_tile(t);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expq.delete();
    part.delete();
    row_idx = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_rowmax", out_row_max, 0);
    chk("rst_done", out_done, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, expected 0", expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_row_lat(input logic [TW-1:0] t0,
                              input logic [TW-1:0] t1);
    beat(t0, 0);
    beat(t1, 0);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
  endtask

  initial begin
    logic [TW-1:0] t0, t1;
    int nlast, ndone;

    repeat (3) @(negedge clk);
    do_reset();

    // ascending row, max 0x1000
    send_row_lat(mk(16'h0100, 16'h0100), mk(16'h0900, 16'h0100));
    chk("t1_rowmax", out_row_max, 16'h1000);
    chk("t1_lane0", ln(out_data, 0), 16'hF100);
    chk("t1_last0", out_last, 0);
    @(negedge clk);
    chk("t1_last1", out_last, 1);
    chk("t1_b1lane0", ln(out_data, 0), 16'hF900);
    chk("t1_lane7", ln(out_data, 7), 16'h0000);
    wait_drain();

    // most-negative lanes against a most-positive max
    t0 = {TS{16'h8000}};
    t0[3*W +: W] = 16'h7FFF;
    t1 = {TS{16'h8000}};
    send_row_lat(t0, t1);
    chk("t2_rowmax", out_row_max, 16'h7FFF);
    chk("t2_sat", ln(out_data, 0), 16'h8000);
    chk("t2_zero", ln(out_data, 3), 16'h0000);
    wait_drain();

    // back-to-back: four rows, in_valid held high for 8 beats
    do_reset();
    nlast = 0;
    ndone = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, (j >= 5 && j <= 12));
      chk("b2b_done", out_done, (j == 12));
      if (out_last) nlast++;
      if (out_done) ndone++;
      if (j < 8) begin
        in_valid = 1'b1;
        in_data  = mk(j * 16'h0111 - 16'h0400, 16'h0031 * (j + 1));
        model_tile(in_data);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_nlast", nlast, 4);
    chk("b2b_ndone", ndone, 1);
    chk("b2b_ovf", overflow, 0);
    wait_drain();

    // four rows with random 50% gaps, max in lane 0 of tile 0
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < TPR; k++) begin
        for (int i = 0; i < TS; i++)
          t0[i*W +: W] = 16'($urandom_range(0, 32767)) - 16'h4000;
        if (k == 0) t0[W-1:0] = 16'h5000 + 16'(r);
        if ($urandom_range(0, 1) == 1) idle();
        beat(t0, 0);
      end
    end
    idle();
    wait_drain();
    chk("gap_ovf", overflow, 0);

    // reset mid-row 1 discards everything buffered
    beat(mk(16'h0010, 16'h0010), 0);
    beat(mk(16'h0090, 16'h0010), 0);
    beat(mk(16'h0200, 16'h0001), 0);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rst_stale", out_valid, 0);
    end
    send_row_lat(mk(16'h0100, 16'h0100), mk(16'h0900, 16'h0100));
    chk("rst_rowmax", out_row_max, 16'h1000);
    wait_drain();

    // drain held off: third row has no free bank
    do_reset();
    drain_hold = 1'b1;
    beat(mk(16'h0005, 16'h0003), 0);
    beat(mk(-16'h0020, 16'h0002), 0);
    beat(mk(16'h1000, -16'h0100), 0);
    beat(mk(16'h0300, 16'h0001), 0);
    beat(mk(16'h0777, 16'h0001), 1);
    beat(mk(16'h0888, 16'h0001), 1);
    repeat (4) idle();
    chk("ovf_hold_valid", out_valid, 0);
    chk("ovf_set", overflow, 1);
    drain_hold = 1'b0;
    wait_drain();
    chk("ovf_sticky", overflow, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
